// File: rtl/palette_fade_ram_if.sv
// Palette lookup/write bus for palette_fade_ram.
//   master : pixel-path side; drives lookups and palette writes, receives RGB.
//   slave  : palette side; receives lookups and writes, returns RGB.
// Signals:
//   pix_valid/index/bank_sel          - colour lookup request
//   wr_en/wr_bank/wr_index/wr_rgb     - palette write, wr_rgb = {R,G,B}
//   rgb_valid/red/green/blue          - looked-up colour, 2 cycles after request
interface palette_fade_ram_if #(
  parameter int INDEX_W = 5,
  parameter int CHAN_W  = 4,
  parameter int BANKS   = 2
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic                 pix_valid;
  logic [INDEX_W-1:0]   index;
  logic [BANK_W-1:0]    bank_sel;
  logic                 wr_en;
  logic [BANK_W-1:0]    wr_bank;
  logic [INDEX_W-1:0]   wr_index;
  logic [3*CHAN_W-1:0]  wr_rgb;
  logic                 rgb_valid;
  logic [CHAN_W-1:0]    red;
  logic [CHAN_W-1:0]    green;
  logic [CHAN_W-1:0]    blue;

  modport master (
    output pix_valid, index, bank_sel, wr_en, wr_bank, wr_index, wr_rgb,
    input  rgb_valid, red, green, blue
  );

  modport slave (
    input  pix_valid, index, bank_sel, wr_en, wr_bank, wr_index, wr_rgb,
    output rgb_valid, red, green, blue
  );
endinterface

// File: rtl/palette_fade_ram.sv
// Run-time writable multi-bank colour palette with global brightness fade.
// A colour index is converted to {R,G,B} through a fixed 2-stage pipeline:
//   S1 registers the palette read (and the brightness level in force),
//   S2 registers the brightness-scaled colour.
// Optional fade logic is enabled by defining PAL_FADE_EN; without it the
// colour passes unscaled, fade_busy is 0 and fade_level is FADE_STEPS.
// Ports:
//   clk, rst_n   - pixel clock, asynchronous active-low reset
//   bus          - lookup / write / RGB bus (palette_fade_ram_if.slave)
//   frame_start  - one-cycle pulse per frame
//   fade_cmd     - 00 none, 01 fade out, 10 fade in, 11 snap to full
//   fade_busy    - fade in progress
//   fade_level   - current brightness level 0..FADE_STEPS
module palette_fade_ram #(
  parameter int INDEX_W         = 5,
  parameter int CHAN_W          = 4,
  parameter int BANKS           = 2,
  parameter int FADE_STEPS      = 16,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  palette_fade_ram_if.slave             bus,
  input  logic                          frame_start,
  input  logic [1:0]                    fade_cmd,
  output logic                          fade_busy,
  output logic [$clog2(FADE_STEPS):0]   fade_level
);
  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W   = 3 * CHAN_W;
  localparam int LVL_W   = $clog2(FADE_STEPS) + 1;

  logic [RGB_W-1:0]  mem [BANKS][ENTRIES];
  logic [BANK_W-1:0] rd_bank;
  logic [BANK_W-1:0] wr_bank;
  logic [RGB_W-1:0]  s1_rgb;
  logic              s1_valid;
  logic [RGB_W-1:0]  s2_rgb;
  logic              s2_valid;
  logic [RGB_W-1:0]  scaled;

  // A single-bank build still carries a 1-bit select; force it to bank 0.
  assign rd_bank = (BANKS > 1) ? bus.bank_sel : '0;
  assign wr_bank = (BANKS > 1) ? bus.wr_bank  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < BANKS; b++)
        for (int unsigned i = 0; i < ENTRIES; i++)
          mem[b][i] <= '0;
    end else if (bus.wr_en) begin
      mem[wr_bank][bus.wr_index] <= bus.wr_rgb;
    end
  end

  // S1 reads the array before the same-edge write lands, so a colliding
  // lookup returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_rgb   <= mem[rd_bank][bus.index];
      s1_valid <= bus.pix_valid;
    end
  end

`ifdef PAL_FADE_EN
  localparam int SHIFT  = $clog2(FADE_STEPS);
  localparam int PROD_W = CHAN_W + SHIFT + 1;
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FADE_OUT = 2'd1;
  localparam logic [1:0] FADE_IN  = 2'd2;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FADE_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [1:0]        state;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  frame_cnt;
  logic [LVL_W-1:0]  s1_level;
  logic [PROD_W-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      level     <= LVL_FULL;
      frame_cnt <= '0;
    end else if (fade_cmd == 2'b11) begin
      state     <= IDLE;
      level     <= LVL_FULL;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fade_cmd == 2'b01 && level != '0) begin
            state     <= FADE_OUT;
            frame_cnt <= '0;
          end else if (fade_cmd == 2'b10 && level != LVL_FULL) begin
            state     <= FADE_IN;
            frame_cnt <= '0;
          end
        end
        FADE_OUT: begin
          if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
              level     <= level - 1'b1;
              frame_cnt <= '0;
              if (level == LVL_W'(1)) state <= IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        FADE_IN: begin
          if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
              level     <= level + 1'b1;
              frame_cnt <= '0;
              if (level == LVL_FULL - 1'b1) state <= IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Level travels with the colour so one pixel never mixes two levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_level <= LVL_FULL;
    else        s1_level <= level;
  end

  always_comb begin
    scaled = '0;
    prod   = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      prod = PROD_W'(s1_rgb[ch*CHAN_W +: CHAN_W]) * PROD_W'(s1_level);
      scaled[ch*CHAN_W +: CHAN_W] = CHAN_W'(prod >> SHIFT);
    end
  end

  assign fade_busy  = (state != IDLE);
  assign fade_level = level;
`else
  localparam int unused_frames_per_step = FRAMES_PER_STEP;
  logic unused_fade;

  assign unused_fade = ^{frame_start, fade_cmd};
  assign scaled      = s1_rgb;
  assign fade_busy   = 1'b0;
  assign fade_level  = LVL_W'(FADE_STEPS);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_rgb   <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_rgb   <= scaled;
      s2_valid <= s1_valid;
    end
  end

  assign bus.rgb_valid = s2_valid;
  assign bus.red       = s2_rgb[3*CHAN_W-1:2*CHAN_W];
  assign bus.green     = s2_rgb[2*CHAN_W-1:CHAN_W];
  assign bus.blue      = s2_rgb[CHAN_W-1:0];
endmodule

// File: doc/palette_fade_ram.md
Name: palette_fade_ram

Overview:
- Parametrised, run-time-writable, multi-bank colour palette for the VGA pixel path.
- Replaces fixed per-sprite palette ROMs.
- Converts a sprite/background colour index into 12-bit RGB through a 2-stage registered pipeline.
- Applies a frame-synchronous global brightness fade used for screen transitions (room change, game over).

Parameters:
- INDEX_W, 5: colour index width; the palette holds 2^INDEX_W entries per bank.
- CHAN_W, 4: bits per colour channel.
- BANKS, 2: number of independent palettes; power of 2, at least 1.
- FADE_STEPS, 16: brightness levels 0..FADE_STEPS; power of 2.
- FRAMES_PER_STEP, 2: frame_start pulses per brightness step; at least 1.

Ports:
- Clk, input, 1: pixel clock.
- Reset_n, input, 1: asynchronous active-low reset.
- pix_valid, input, 1: index/bank_sel valid this cycle.
- index, input, INDEX_W: colour index to look up.
- bank_sel, input, log2(BANKS) (min 1): bank for the lookup.
- wr_en, input, 1: palette write strobe.
- wr_bank, input, log2(BANKS) (min 1): bank to write.
- wr_index, input, INDEX_W: entry to write.
- wr_rgb, input, 3*CHAN_W: {R,G,B} write data.
- frame_start, input, 1: one-cycle pulse per frame (start of vsync).
- fade_cmd, input, 2: 00 none, 01 fade out, 10 fade in, 11 snap to full brightness.
- fade_busy, output, 1: high while a fade is in progress.
- fade_level, output, log2(FADE_STEPS)+1: current brightness level.
- rgb_valid, output, 1: red/green/blue are valid this cycle.
- red, green, blue, output, CHAN_W each: scaled colour.

Behaviour:
- Reset (async, Reset_n low):
  - All palette entries = 0.
  - level = FADE_STEPS; state = IDLE; frame counter = 0.
  - rgb_valid = 0; red/green/blue = 0; fade_busy = 0.
- Storage: BANKS x 2^INDEX_W x 3*CHAN_W flop array.
  - Write is synchronous on wr_en.
  - Out-of-range wr_bank (BANKS not a power of 2 is illegal, so none) needs no handling.
- Pipeline, fixed latency 2 cycles, no stalls:
  - S1 registers the array read {R,G,B}, plus pix_valid.
  - S2 registers the scaled colour, and rgb_valid = S1 valid.
  - When the S1 valid bit is 0, S2 still updates colour but rgb_valid = 0.
- Read/write collision (same bank and index in the same cycle): read returns the OLD entry; the new value is visible from the next lookup.
- Scaling per channel: out = (c * level) >> log2(FADE_STEPS).
  - Product width is CHAN_W + log2(FADE_STEPS) + 1; truncate toward zero.
  - level = FADE_STEPS passes c unchanged; level = 0 yields 0.
  - The level used is the one sampled at S1, so a colour never mixes levels.
- Fade FSM, states IDLE, FADE_OUT, FADE_IN:
  - IDLE + cmd 01 with level > 0 goes to FADE_OUT; cmd 10 with level < FADE_STEPS goes to FADE_IN. The frame counter clears on entry.
  - cmd 01 at level 0, or cmd 10 at full: no effect, and fade_busy stays 0.
  - cmd 11 (any state): level = FADE_STEPS, state = IDLE, counter = 0 in the next cycle. Overrides all other events.
  - cmd 01/10 while busy: ignored.
  - In FADE_x on frame_start: if counter = FRAMES_PER_STEP-1, then level -/+ 1 and counter = 0; else counter + 1.
  - When the update makes level reach 0 (out) or FADE_STEPS (in), state becomes IDLE in the same cycle.
  - frame_start in IDLE is ignored.
  - frame_start coinciding with the accepting command: the command takes priority, and that pulse does not count.
- fade_busy = (state != IDLE), registered. fade_level mirrors level.
- Reset mid-fade: immediate full brightness and IDLE. The palette contents are lost (software must reload).

Optional Feature:
- Macro PAL_FADE_EN.
- Defined: fade FSM, counter and multiplier as above.
- Undefined:
  - FSM, counter and multiplier are removed.
  - fade_cmd and frame_start are ignored.
  - fade_busy is tied 0; fade_level is tied FADE_STEPS.
  - S2 passes the S1 colour unscaled. Latency stays 2 cycles.

Test Plan:
- Reset, then look up bank 0 index 7 -> 2 cycles later rgb_valid = 1, RGB = 0,0,0; fade_level = 16.
- Write bank 0 idx 5 = 0xE41 and bank 1 idx 5 = 0x05E, then look up both -> E,4,1 then 0,5,E on consecutive cycles at latency 2.
- Write idx 3 = 0xFA5 and look up idx 3 in the same cycle (prior value 0x000) -> 0,0,0 returned; the next lookup returns F,A,5.
- fade_cmd = 01, then 16 frame_start pulses (FRAMES_PER_STEP = 2) -> level 8, palette 0xE41 outputs 7,2,0; after 32 pulses level 0, output 0,0,0, fade_busy falls in the same cycle as the final step.
- During a fade, issue cmd 10 (ignored), then cmd 11 -> level 16 and fade_busy = 0 the next cycle. Assert Reset_n low mid-fade -> outputs 0 asynchronously; after release, level = 16.
- Build without PAL_FADE_EN: cmd 01 plus 40 frame pulses -> 0xE41 still outputs E,4,1; fade_busy = 0 throughout.
